// File: rtl/viewport_pkg.sv
// viewport_pkg: shared types, defaults and packing helpers for the viewport scaler
package viewport_pkg;
    localparam int FRAC_DEF = 10;
    localparam logic [20:0] SCALE_X_DEF = 21'h2800;
    localparam logic [20:0] SCALE_Y_DEF = 21'h1E00;
    typedef enum logic [1:0] {IDLE, SCALE, DONE} state_t;
    function automatic int vtx_lsb(input int k, input int w);
        return 3 * k * w;
    endfunction
endpackage

// File: rtl/viewport_scaler_pipe_if.sv
// viewport_scaler_pipe_if: primitive handshake, config and result bundle
interface viewport_scaler_pipe_if #(parameter int VTX_CNT = 4, parameter int W = 21);
    logic in_valid, in_ready, out_valid, out_ready;
    logic [VTX_CNT*3*W-1:0] in_vtx, out_vtx;
    logic signed [W-1:0] cfg_scale_x, cfg_scale_y, cfg_off_x, cfg_off_y;
    logic [VTX_CNT-1:0] out_sat;
    modport master (
        output in_valid, in_vtx, cfg_scale_x, cfg_scale_y, cfg_off_x, cfg_off_y, out_ready,
        input in_ready, out_valid, out_vtx, out_sat
    );
    modport slave (
        input in_valid, in_vtx, cfg_scale_x, cfg_scale_y, cfg_off_x, cfg_off_y, out_ready,
        output in_ready, out_valid, out_vtx, out_sat
    );
endinterface

// File: rtl/scale_sat_lane.sv
// scale_sat_lane: one coordinate, sat(((raw*scale)>>>FRAC)+off) with clamp flag
module scale_sat_lane #(parameter int W = 21, parameter int FRAC = 10) (
    input  logic signed [W-1:0] raw,
    input  logic signed [W-1:0] scale,
    input  logic signed [W-1:0] off,
    output logic signed [W-1:0] val,
    output logic                sat
);
    logic signed [2*W-1:0] prod, shifted;
    logic signed [2*W:0] sum;
    assign prod = (2*W)'(raw) * (2*W)'(scale);
    assign shifted = prod >>> FRAC;
    assign sum = (2*W+1)'(shifted) + (2*W+1)'(off);
    // in range only when every bit above the result sign matches it
    assign sat = ~(&sum[2*W:W-1] | ~|sum[2*W:W-1]);
    assign val = sat ? (sum[2*W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : sum[W-1:0];
endmodule

// File: rtl/viewport_scaler_pipe.sv
// viewport_scaler_pipe: sequential NDC-to-screen scaler, one vertex per cycle
module viewport_scaler_pipe
    import viewport_pkg::*;
#(
    parameter int VTX_CNT = 4,
    parameter int W = 21,
    parameter int FRAC = FRAC_DEF,
    parameter int IDX_W = 3
) (
    input logic clk,
    input logic rst,
    viewport_scaler_pipe_if.slave bus
);
    localparam int VW = 3 * W;
    localparam int DW = VTX_CNT * VW;
    state_t state;
    logic [IDX_W-1:0] k;
    logic [DW-1:0] vtx_r;
    logic signed [W-1:0] sx_r, sy_r, ox_r, oy_r;
    logic signed [W-1:0] x_raw, y_raw, z_raw, x_val, y_val;
    logic x_sat, y_sat;
    always_comb begin
        x_raw = '0;
        y_raw = '0;
        z_raw = '0;
        for (int i = 0; i < VTX_CNT; i++) begin
            if (k == IDX_W'(i)) begin
                x_raw = vtx_r[vtx_lsb(i, W) +: W];
                y_raw = vtx_r[vtx_lsb(i, W) + W +: W];
                z_raw = vtx_r[vtx_lsb(i, W) + 2*W +: W];
            end
        end
    end
    scale_sat_lane #(.W(W), .FRAC(FRAC)) lane_x (.raw(x_raw), .scale(sx_r), .off(ox_r), .val(x_val), .sat(x_sat));
    scale_sat_lane #(.W(W), .FRAC(FRAC)) lane_y (.raw(y_raw), .scale(sy_r), .off(oy_r), .val(y_val), .sat(y_sat));
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k <= '0;
            bus.in_ready <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_vtx <= '0;
            bus.out_sat <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        vtx_r <= bus.in_vtx;
                        sx_r <= bus.cfg_scale_x;
                        sy_r <= bus.cfg_scale_y;
                        ox_r <= bus.cfg_off_x;
                        oy_r <= bus.cfg_off_y;
                        k <= '0;
                        bus.in_ready <= 1'b0;
                        state <= SCALE;
                    end else begin
                        bus.in_ready <= 1'b1;
                    end
                end
                SCALE: begin
                    for (int i = 0; i < VTX_CNT; i++) begin
                        if (k == IDX_W'(i)) begin
                            bus.out_vtx[vtx_lsb(i, W) +: VW] <= {z_raw, y_val, x_val};
                            bus.out_sat[i] <= x_sat | y_sat;
                        end
                    end
                    k <= k + 1'b1;
                    if (k == IDX_W'(VTX_CNT - 1)) begin
                        bus.out_valid <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
